// File: rtl/md_scheduler_if.sv
// Handshake and result bundle between the E-stage issue logic and the mult/div sequencer.
// The master side issues operations and reads HI/LO; the slave side is the sequencer.
interface md_scheduler_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, md_use_D,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start, op, a, b, md_use_D,
    output busy, stall_md, hi, lo
  );
endinterface

// File: rtl/md_scheduler.sv
// Multi-cycle multiply/divide sequencer: computes at issue, holds HI/LO busy for a fixed
// latency, then commits. Also produces the HI/LO stall contribution for the hazard unit.
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  md_scheduler_if.slave md
);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  localparam logic [7:0] MultLoad = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] DivLoad  = 8'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        commit_q, commit_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Multiply: low 64 bits of the product of sign- or zero-extended operands.
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, prod;

  assign mul_signed = (md.op == OpMult);
  assign mul_a      = {{32{mul_signed & md.a[31]}}, md.a};
  assign mul_b      = {{32{mul_signed & md.b[31]}}, md.b};
  assign prod       = mul_a * mul_b;

  // Divide on magnitudes, then fix signs; avoids the INT_MIN / -1 overflow corner.
  logic        div_signed, neg_a, neg_b, div_zero;
  logic [31:0] mag_a, mag_b, div_den, quo_mag, rem_mag, quo, rem;

  assign div_signed = (md.op == OpDiv);
  assign neg_a      = div_signed & md.a[31];
  assign neg_b      = div_signed & md.b[31];
  assign mag_a      = neg_a ? (32'd0 - md.a) : md.a;
  assign mag_b      = neg_b ? (32'd0 - md.b) : md.b;
  assign div_zero   = (md.b == 32'd0);
  assign div_den    = div_zero ? 32'd1 : mag_b;
  assign quo_mag    = mag_a / div_den;
  assign rem_mag    = mag_a % div_den;
  assign quo        = (neg_a ^ neg_b) ? (32'd0 - quo_mag) : quo_mag;
  assign rem        = neg_a ? (32'd0 - rem_mag) : rem_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      StIdle: begin
        if (md.start) begin
          case (md.op)
            OpMult, OpMultu: begin
              res_hi_d = prod[63:32];
              res_lo_d = prod[31:0];
              commit_d = 1'b1;
              cnt_d    = MultLoad;
              state_d  = StRun;
            end
            OpDiv, OpDivu: begin
              res_hi_d = rem;
              res_lo_d = quo;
              // Divide by zero still occupies the unit but leaves HI/LO untouched.
              commit_d = ~div_zero;
              cnt_d    = DivLoad;
              state_d  = StRun;
            end
            OpMthi: hi_d = md.a;
            OpMtlo: lo_d = md.a;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (cnt_q == 8'd0) begin
          if (commit_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      commit_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign md.busy     = (state_q == StRun);
  assign md.stall_md = md.md_use_D & (md.busy | md.start);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: expected HI/LO pairs are queued at issue and
// compared when busy falls; busy length and stall_md are checked every cycle.
module tb_md_scheduler;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  md_scheduler_if md_if ();

  md_scheduler #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (md_if)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: 64-bit arithmetic, independent of the DUT's magnitude/sign approach.
  task automatic predict(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] hl, output int n);
    longint      sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hl = {m_hi, m_lo};
    n  = int'(DivN);
    case (op)
      OpMult:  begin hl = 64'(sa * sb); n = int'(MultN); end
      OpMultu: begin hl = {32'd0, a} * {32'd0, b}; n = int'(MultN); end
      OpDiv, OpDivu: begin
        if (b != 32'd0) begin
          if (op == OpDivu) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
          end
          q  = sa / sb;
          r  = sa % sb;
          qv = 64'(q);
          rv = 64'(r);
          hl = {rv[31:0], qv[31:0]};
        end
      end
      default: ;
    endcase
    m_hi = hl[63:32];
    m_lo = hl[31:0];
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic use_d, input bit inject);
    logic [63:0] hl, exp;
    int          n, cycles;
    predict(op, a, b, hl, n);
    exp_q.push_back(hl);
    @(negedge clk);
    check({tag, "_idle"}, 64'(md_if.busy), 64'd0);
    md_if.start    = 1'b1;
    md_if.op       = op;
    md_if.a        = a;
    md_if.b        = b;
    md_if.md_use_D = use_d;
    #1;
    check({tag, "_stall_issue"}, 64'(md_if.stall_md), 64'(use_d));
    @(negedge clk);
    md_if.start = 1'b0;
    cycles = 0;
    while (md_if.busy && cycles < 300) begin
      check({tag, "_stall_run"}, 64'(md_if.stall_md), 64'(use_d));
      cycles++;
      if (inject && cycles == 2) begin
        md_if.start = 1'b1;
        md_if.op    = OpMthi;
        md_if.a     = 32'h0000_ABCD;
      end else begin
        md_if.start = 1'b0;
      end
      @(negedge clk);
    end
    md_if.start = 1'b0;
    #1;
    check({tag, "_busy_cycles"}, 64'(cycles), 64'(n));
    check({tag, "_stall_after"}, 64'(md_if.stall_md), 64'd0);
    exp = exp_q.pop_front();
    check({tag, "_hi"}, 64'(md_if.hi), 64'(exp[63:32]));
    check({tag, "_lo"}, 64'(md_if.lo), 64'(exp[31:0]));
    md_if.md_use_D = 1'b0;
  endtask

  task automatic write_hilo(input string tag, input logic [2:0] op, input logic [31:0] val);
    @(negedge clk);
    md_if.start = 1'b1;
    md_if.op    = op;
    md_if.a     = val;
    @(negedge clk);
    md_if.start = 1'b0;
    if (op == OpMthi) m_hi = val;
    else m_lo = val;
    check({tag, "_busy"}, 64'(md_if.busy), 64'd0);
    check({tag, "_hi"}, 64'(md_if.hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(md_if.lo), 64'(m_lo));
  endtask

  initial begin
    reset          = 1'b0;
    md_if.start    = 1'b0;
    md_if.op       = 3'b111;
    md_if.a        = 32'd0;
    md_if.b        = 32'd0;
    md_if.md_use_D = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(md_if.busy), 64'd0);
    check("rst_stall", 64'(md_if.stall_md), 64'd0);
    check("rst_hi", 64'(md_if.hi), 64'd0);
    check("rst_lo", 64'(md_if.lo), 64'd0);
    reset = 1'b1;

    // Constant expectations from the worked examples, then the model for the same ops.
    run_op("mult_neg", OpMult, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    check("mult_neg_const", {md_if.hi, md_if.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_neg_const", {md_if.hi, md_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu", OpDivu, 32'd7, 32'd2, 1'b0, 1'b0);
    check("divu_const", {md_if.hi, md_if.lo}, 64'h0000_0001_0000_0003);

    write_hilo("mthi", OpMthi, 32'h11);
    write_hilo("mtlo", OpMtlo, 32'h22);
    run_op("divu_zero", OpDivu, 32'd1234, 32'd0, 1'b0, 1'b0);
    check("divu_zero_const", {md_if.hi, md_if.lo}, 64'h0000_0011_0000_0022);
    run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_ovf_const", {md_if.hi, md_if.lo}, 64'h0000_0000_8000_0000);

    run_op("mult_stall", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("mult_inject", OpMult, 32'h1234_5678, 32'hFEDC_BA98, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      run_op("rand", rop, ra, rb, 1'(i % 2), 1'b0);
    end

    // Asynchronous reset in the middle of a divide.
    write_hilo("pre_rst_hi", OpMthi, 32'h55);
    write_hilo("pre_rst_lo", OpMtlo, 32'h66);
    @(negedge clk);
    md_if.start = 1'b1;
    md_if.op    = OpDiv;
    md_if.a     = 32'd100;
    md_if.b     = 32'd7;
    @(negedge clk);
    md_if.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(md_if.busy), 64'd0);
    check("arst_hi", 64'(md_if.hi), 64'd0);
    check("arst_lo", 64'(md_if.lo), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_busy", 64'(md_if.busy), 64'd0);
    check("post_rst_hi", 64'(md_if.hi), 64'd0);
    check("post_rst_lo", 64'(md_if.lo), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
